// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the datapath.
// The master modport is the sequencer side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             imem_req;
    logic             imem_ready;
    logic [31:0]      instr;
    logic             EQ;
    logic             IRwrite;
    logic             PCwrite;
    logic             PCsrc;
    logic             RegWrite;
    logic [2:0]       ALUctrl;
    logic             ALUsrc;
    logic             ImmSrc;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  imem_ready, instr, EQ,
        output imem_req, IRwrite, PCwrite, PCsrc, RegWrite,
        output ALUctrl, ALUsrc, ImmSrc, illegal, retired
    );

    modport slave (
        output imem_ready, instr, EQ,
        input  imem_req, IRwrite, PCwrite, PCsrc, RegWrite,
        input  ALUctrl, ALUsrc, ImmSrc, illegal, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch, decode OP-IMM / BEQ / BNE, execute,
// write back, and count retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC_I, WB_I, EXEC_B, ILLEGAL
    } state_t;

    state_t state, nxt;
    logic [CNT_W-1:0] cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       op_imm;
    logic       op_br;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign op_imm = (opcode == 7'b0010011);
    assign op_br  = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);

    logic       req, irw, pcw, pcs, rw, asrc, isrc, ill;
    logic [2:0] actl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= nxt;
    end

    always_comb begin
        nxt  = state;
        req  = 1'b0;
        irw  = 1'b0;
        pcw  = 1'b0;
        pcs  = 1'b0;
        rw   = 1'b0;
        asrc = 1'b0;
        isrc = 1'b0;
        actl = 3'b000;
        ill  = 1'b0;
        unique case (state)
            FETCH: begin
                req = 1'b1;
                if (bus.imem_ready) begin
                    irw = 1'b1;
                    nxt = DECODE;
                end
            end
            DECODE: begin
                unique case (1'b1)
                    op_imm:  nxt = EXEC_I;
                    op_br:   nxt = EXEC_B;
                    default: nxt = ILLEGAL;
                endcase
            end
            EXEC_I: begin
                asrc = 1'b1;
                isrc = 1'b1;
                actl = funct3;
                nxt  = WB_I;
            end
            WB_I: begin
                asrc = 1'b1;
                isrc = 1'b1;
                actl = funct3;
                rw   = 1'b1;
                pcw  = 1'b1;
                nxt  = FETCH;
            end
            EXEC_B: begin
                pcw = 1'b1;
                // funct3[0] distinguishes BNE from BEQ
                pcs = bus.EQ ^ funct3[0];
                nxt = FETCH;
            end
            ILLEGAL: begin
                ill = 1'b1;
                pcw = 1'b1;
                nxt = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state == WB_I || state == EXEC_B)
            cnt <= cnt + 1'b1;
    end

    // Reset forces every control output low, FETCH included
    assign bus.imem_req = req  & rst_n;
    assign bus.IRwrite  = irw  & rst_n;
    assign bus.PCwrite  = pcw  & rst_n;
    assign bus.PCsrc    = pcs  & rst_n;
    assign bus.RegWrite = rw   & rst_n;
    assign bus.ALUsrc   = asrc & rst_n;
    assign bus.ImmSrc   = isrc & rst_n;
    assign bus.illegal  = ill  & rst_n;
    assign bus.ALUctrl  = actl & {3{rst_n}};
    assign bus.retired  = cnt;
endmodule
